// File: rtl/br_rx_buffer_pkg.sv
// DMNIPkg slice used by the BrLite receive buffer: the shared broadcast payload type
// and the router-side handshake state encoding.
package DMNIPkg;

    typedef struct packed {
        logic [3:0]  ksvc;
        logic [15:0] seq_source;
        logic [15:0] payload;
    } br_payload_t;

    typedef enum logic {
        BR_RX_IDLE,
        BR_RX_WAIT_LOW
    } br_rx_state_t;

endpackage

// File: rtl/br_rx_fifo.sv
// Register FIFO of BrLite payloads with head-of-queue read and next-occupancy export.
// A pop on an empty FIFO is dropped; the caller only pushes when not full.
module br_rx_fifo
    import DMNIPkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  br_payload_t              push_data,
    input  logic                     pop,
    output br_payload_t              head,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    br_payload_t        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Payload storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/br_rx_buffer.sv
// BrLite router-to-DMNI receive buffer: req/ack intake FSM in front of a small FIFO.
// Optional statistics (accept counter, occupancy high-water) under BRLITE_RX_STATS_EN.
module br_rx_buffer
    import DMNIPkg::*;
#(
    parameter int BUFFER_SIZE = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           rx_req_i,
    output logic                           rx_ack_o,
    input  br_payload_t                    rx_data_i,
    output logic                           ni_rx_o,
    input  logic                           ni_ack_i,
    output br_payload_t                    ni_data_o,
    output logic                           full_o,
    output logic [31:0]                    rcv_count_o,
    output logic [$clog2(BUFFER_SIZE):0]   high_water_o
);

    localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

    br_rx_state_t       state;
    br_rx_state_t       state_next;
    logic               push;
    logic               empty;
    logic [CNT_W-1:0]   count_next;

    // A held req after an accept is ignored until it drops, so no message is taken twice.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            BR_RX_IDLE: begin
                if (rx_req_i && !full_o) begin
                    push       = 1'b1;
                    state_next = BR_RX_WAIT_LOW;
                end
            end
            BR_RX_WAIT_LOW: begin
                if (!rx_req_i) begin
                    state_next = BR_RX_IDLE;
                end
            end
            default: state_next = BR_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= BR_RX_IDLE;
            rx_ack_o <= 1'b0;
        end else begin
            state    <= state_next;
            rx_ack_o <= push;
        end
    end

    br_rx_fifo #(
        .DEPTH (BUFFER_SIZE)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .push_data  (rx_data_i),
        .pop        (ni_ack_i),
        .head       (ni_data_o),
        .count_next (count_next),
        .full       (full_o),
        .empty      (empty)
    );

    assign ni_rx_o = !empty;

`ifdef BRLITE_RX_STATS_EN
    logic [31:0]      rcv_count;
    logic [CNT_W-1:0] high_water;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rcv_count  <= '0;
            high_water <= '0;
        end else begin
            if (push) begin
                rcv_count <= rcv_count + 32'd1;
            end
            if (count_next > high_water) begin
                high_water <= count_next;
            end
        end
    end

    assign rcv_count_o  = rcv_count;
    assign high_water_o = high_water;
`else
    logic unused_count_next;

    assign unused_count_next = ^count_next;
    assign rcv_count_o       = '0;
    assign high_water_o      = '0;
`endif

endmodule
